// File: rtl/modulo_entrada.sv
// modulo_entrada: input-side responder for the IN instruction.
// Synchronizes and debounces the enter key, captures the switch bank once per
// press into a one-entry buffer, and hands it to the control unit as a
// one-cycle pronto pulse with a 32-bit extended word.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   chave      raw enter key (async, active-high)
//   dadosIN    raw 8-bit switch bank (async)
//   req        control unit waiting for IN data
//   dados      last delivered word, stable between deliveries
//   pronto     one-cycle pulse, dados valid in the same cycle
//   aguardando req high while the buffer is empty (combinational)
//   perdido    sticky overrun flag
module modulo_entrada #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          SIGN_EXT        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chave,
  input  logic [7:0]  dadosIN,
  input  logic        req,
  output logic [31:0] dados,
  output logic        pronto,
  output logic        aguardando,
  output logic        perdido
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXT_W  = WORD_W - BYTE_W;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    OCIOSO,
    CONFIRMA,
    PRESSIONADO,
    SOLTA
  } estado_t;

  logic              k_s1_q, k_s1_d, k_s_q, k_s_d;
  logic [BYTE_W-1:0] d_s1_q, d_s1_d, d_s_q, d_s_d;
  estado_t           estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic [WORD_W-1:0] dados_q, dados_d;
  logic              pronto_q, pronto_d;
  logic              perdido_q, perdido_d;
  logic              captura;
  logic              entrega;
  logic [WORD_W-1:0] estendido;

  // Two-flop synchronizers for the key and the switch bank
  always_comb begin
    k_s1_d = chave;
    k_s_d  = k_s1_q;
    d_s1_d = dadosIN;
    d_s_d  = d_s1_q;
  end

  // Debounce FSM: a press is accepted after DEBOUNCE_CYCLES+1 stable high
  // samples, and re-armed only after the same number of stable low samples
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    captura  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (k_s_q) begin
          estado_d = CONFIRMA;
          cnt_d    = CNT_W'(1);
        end
      end
      CONFIRMA: begin
        if (!k_s_q) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else if (cnt_q >= CNT_MAX) begin
          captura  = 1'b1;
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        if (!k_s_q) begin
          estado_d = SOLTA;
          cnt_d    = CNT_W'(1);
        end
      end
      SOLTA: begin
        if (k_s_q) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q >= CNT_MAX) begin
          estado_d = OCIOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
  end

  // Buffer and delivery: a capture coinciding with a delivery refills the
  // buffer behind the outgoing byte without counting as an overrun
  always_comb begin
    entrega     = req & buf_valid_q;
    estendido   = SIGN_EXT ? {{EXT_W{buf_q[BYTE_W-1]}}, buf_q}
                           : {{EXT_W{1'b0}}, buf_q};
    pronto_d    = entrega;
    dados_d     = entrega ? estendido : dados_q;
    buf_d       = captura ? d_s_q : buf_q;
    buf_valid_d = captura | (buf_valid_q & ~entrega);
    perdido_d   = perdido_q | (captura & buf_valid_q & ~entrega);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_s1_q      <= 1'b0;
      k_s_q       <= 1'b0;
      d_s1_q      <= '0;
      d_s_q       <= '0;
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      dados_q     <= '0;
      pronto_q    <= 1'b0;
      perdido_q   <= 1'b0;
    end else begin
      k_s1_q      <= k_s1_d;
      k_s_q       <= k_s_d;
      d_s1_q      <= d_s1_d;
      d_s_q       <= d_s_d;
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      dados_q     <= dados_d;
      pronto_q    <= pronto_d;
      perdido_q   <= perdido_d;
    end
  end

  assign dados      = dados_q;
  assign pronto     = pronto_q;
  assign perdido    = perdido_q;
  assign aguardando = req & ~buf_valid_q;

endmodule

// File: tb/tb_modulo_entrada.sv
// Testbench for modulo_entrada: two instances (zero- and sign-extending) share
// the same stimulus and are compared every cycle against a behavioural model
// built from press/release run lengths and a one-entry buffer.
module tb_modulo_entrada;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chave = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  dadosIN = '0;
  logic [31:0] dados0, dados1;
  logic        pronto0, pronto1, aguardando0, aguardando1, perdido0, perdido1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modulo_entrada #(.DEBOUNCE_CYCLES(D), .SIGN_EXT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .chave(chave), .dadosIN(dadosIN), .req(req),
    .dados(dados0), .pronto(pronto0), .aguardando(aguardando0), .perdido(perdido0)
  );

  modulo_entrada #(.DEBOUNCE_CYCLES(D), .SIGN_EXT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .chave(chave), .dadosIN(dadosIN), .req(req),
    .dados(dados1), .pronto(pronto1), .aguardando(aguardando1), .perdido(perdido1)
  );

  // Reference model: key accepted after D+1 consecutive high synchronized
  // samples, re-armed after D+1 consecutive low samples.
  logic       m_k1 = 1'b0, m_k = 1'b0;
  logic [7:0] m_d1 = '0, m_d = '0, m_buf = '0, m_out = '0;
  logic       m_bv = 1'b0, m_pronto = 1'b0, m_perdido = 1'b0;
  bit         armed = 1'b1, m_cap, m_del;
  int         hi_run = 0, lo_run = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_k1 = 0; m_k = 0; m_d1 = '0; m_d = '0; m_buf = '0; m_out = '0;
      m_bv = 0; m_pronto = 0; m_perdido = 0; armed = 1; hi_run = 0; lo_run = 0;
    end else begin
      m_cap = 0;
      if (m_k) begin
        lo_run = 0;
        hi_run++;
        if (armed && hi_run == D + 1) begin
          m_cap = 1;
          armed = 0;
        end
      end else begin
        hi_run = 0;
        lo_run++;
        if (lo_run >= D + 1) armed = 1;
      end
      m_del    = req && m_bv;
      m_pronto = m_del;
      if (m_del) m_out = m_buf;
      if (m_cap && m_bv && !m_del) m_perdido = 1;
      if (m_cap) begin
        m_buf = m_d;
        m_bv  = 1;
      end else if (m_del) begin
        m_bv = 0;
      end
      m_k = m_k1; m_k1 = chave; m_d = m_d1; m_d1 = dadosIN;
    end
  end

  function automatic logic [69:0] obs_v();
    return {pronto0, pronto1, perdido0, perdido1, aguardando0, aguardando1, dados0, dados1};
  endfunction

  function automatic logic [69:0] exp_v();
    logic ag;
    ag = req & ~m_bv;
    return {m_pronto, m_pronto, m_perdido, m_perdido, ag, ag,
            {24'd0, m_out}, {{24{m_out[7]}}, m_out}};
  endfunction

  typedef struct packed {
    logic       k;
    logic [7:0] d;
    logic       r;
  } step_t;

  step_t sched[$];

  // Appends n identical cycles of stimulus to the schedule
  task automatic add(input logic k, input logic [7:0] d, input logic r, input int n);
    step_t s;
    s.k = k; s.d = d; s.r = r;
    repeat (n) sched.push_back(s);
  endtask

  task automatic test_reset();
    int np;
    np = 0;
    rst = 1; chave = 1; dadosIN = 8'hFF; req = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pronto0, perdido0, dados0} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got p=%b l=%b d=%h, need 0", pronto0, perdido0, dados0);
    end
    checks++;
    if (aguardando0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_aguardando: got %b, need 1", aguardando0);
    end
    rst = 0; chave = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL reset_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
      if (pronto0) np++;
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL reset_no_capture: got %0d pronto, need 0", np);
    end
  endtask

  task automatic test_clean_press();
    int np, first;
    np = 0; first = -1;
    add(1, 8'hA5, 1, 8);
    add(1, 8'hA5, 0, 12);
    add(0, 8'hA5, 0, 12);
    for (int i = 0; i < sched.size(); i++) begin
      chave = sched[i].k; dadosIN = sched[i].d; req = sched[i].r;
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL clean_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
      if (i == 0) begin
        checks++;
        if (aguardando0 !== 1'b1) begin
          errors++;
          $display("FAIL clean_aguardando_before: got %b, need 1", aguardando0);
        end
      end
      if (pronto0 === 1'b1) begin
        np++;
        if (first < 0) first = i + 1;
        checks++;
        if (dados0 !== 32'h000000A5) begin
          errors++;
          $display("FAIL clean_dados: got %h, need 000000a5", dados0);
        end
      end
    end
    sched.delete();
    checks++;
    if (np != 1 || first != 8) begin
      errors++;
      $display("FAIL clean_pronto: got %0d pulses first at %0d, need 1 at 8", np, first);
    end
    checks++;
    if (aguardando0 !== 1'b0) begin
      errors++;
      $display("FAIL clean_aguardando_after: got %b, need 0", aguardando0);
    end
  endtask

  task automatic test_bounce();
    int np, np_long;
    logic [7:0] b;
    logic [5:0] pat;
    np = 0; np_long = 0;
    b = 8'($urandom);
    pat = 6'b110110;
    for (int j = 5; j >= 0; j--) add(pat[j], 8'h3C, 1, 1);
    add(0, 8'h3C, 1, 12);
    add(1, b, 1, 12);
    add(0, b, 1, 2);
    add(1, b, 1, 3);
    add(0, b, 0, 12);
    for (int i = 0; i < sched.size(); i++) begin
      chave = sched[i].k; dadosIN = sched[i].d; req = sched[i].r;
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL bounce_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
      if (pronto0 === 1'b1) begin
        if (i < 18) np++;
        else begin
          np_long++;
          checks++;
          if (dados0 !== {24'd0, b}) begin
            errors++;
            $display("FAIL bounce_dados: got %h, need %h", dados0, {24'd0, b});
          end
        end
      end
    end
    sched.delete();
    checks++;
    if (np != 0 || np_long != 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d glitch / %0d long, need 0 / 1", np, np_long);
    end
  endtask

  task automatic test_sign_ext();
    int np, at;
    np = 0; at = -1;
    add(1, 8'h80, 0, 10);
    add(0, 8'h80, 0, 12);
    add(0, 8'h80, 1, 1);
    add(0, 8'h80, 0, 4);
    for (int i = 0; i < sched.size(); i++) begin
      chave = sched[i].k; dadosIN = sched[i].d; req = sched[i].r;
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL signext_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
      if (pronto1 === 1'b1) begin
        np++; at = i + 1;
        checks++;
        if (dados1 !== 32'hFFFFFF80 || dados0 !== 32'h00000080) begin
          errors++;
          $display("FAIL signext_dados: got %h/%h, need ffffff80/00000080", dados1, dados0);
        end
      end
    end
    sched.delete();
    checks++;
    if (np != 1 || at != 23) begin
      errors++;
      $display("FAIL signext_pronto: got %0d pulses at %0d, need 1 at 23", np, at);
    end
  endtask

  task automatic test_overrun();
    int np;
    logic [31:0] got;
    np = 0; got = '0;
    add(1, 8'h01, 0, 10);
    add(0, 8'h01, 0, 12);
    add(1, 8'h02, 0, 10);
    add(0, 8'h02, 0, 12);
    add(0, 8'h02, 1, 1);
    add(0, 8'h02, 0, 6);
    for (int i = 0; i < sched.size(); i++) begin
      chave = sched[i].k; dadosIN = sched[i].d; req = sched[i].r;
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL overrun_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
      if (i == 43) begin
        checks++;
        if (perdido0 !== 1'b1) begin
          errors++;
          $display("FAIL overrun_flag: got %b, need 1", perdido0);
        end
      end
      if (pronto0 === 1'b1) begin
        np++; got = dados0;
      end
    end
    sched.delete();
    checks++;
    if (np != 1 || got !== 32'h00000002) begin
      errors++;
      $display("FAIL overrun_delivery: got %0d pulses dados %h, need 1 with 00000002", np, got);
    end
    checks++;
    if (perdido0 !== 1'b1 || perdido1 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b%b, need 11", perdido0, perdido1);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] got[$];
    int idx[$];
    rst = 1; chave = 0; req = 0;
    @(negedge clk);
    rst = 0;
    add(1, 8'h22, 0, 10);
    add(0, 8'h22, 0, 12);
    add(1, 8'h11, 0, 6);
    add(1, 8'h11, 1, 2);
    add(1, 8'h11, 0, 4);
    add(0, 8'h11, 0, 12);
    for (int i = 0; i < sched.size(); i++) begin
      chave = sched[i].k; dadosIN = sched[i].d; req = sched[i].r;
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL simult_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
      if (pronto0 === 1'b1) begin
        got.push_back(dados0);
        idx.push_back(i);
      end
    end
    sched.delete();
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL simult_count: got %0d pulses, need 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 32'h22 || got[1] !== 32'h11 || idx[1] != idx[0] + 1) begin
        errors++;
        $display("FAIL simult_order: got %h@%0d %h@%0d, need 00000022 then 00000011 back to back",
                 got[0], idx[0], got[1], idx[1]);
      end
    end
    checks++;
    if (perdido0 !== 1'b0) begin
      errors++;
      $display("FAIL simult_perdido: got %b, need 0", perdido0);
    end
  endtask

  task automatic test_random();
    logic       lvl;
    logic [7:0] d;
    rst = 1;
    @(negedge clk);
    rst = 0;
    lvl = 0;
    d = 8'($urandom);
    while (sched.size() < 3000) begin
      int len;
      len = int'($urandom_range(1, 12));
      lvl = ~lvl;
      if ($urandom_range(0, 1) == 0) d = 8'($urandom);
      for (int j = 0; j < len; j++) add(lvl, d, logic'($urandom_range(0, 3) == 0), 1);
    end
    for (int i = 0; i < sched.size(); i++) begin
      chave = sched[i].k; dadosIN = sched[i].d; req = sched[i].r;
      @(negedge clk);
      checks++;
      if (obs_v() !== exp_v()) begin
        errors++;
        $display("FAIL random_model cyc %0d: got %h need %h", i + 1, obs_v(), exp_v());
      end
    end
    sched.delete();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_sign_ext();
    test_overrun();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_entrada.md
Name: modulo_entrada

Overview:
- Input-side responder that pairs with the output display path.
- Turns the raw "enter" key (chave) and the 8-bit switch bank (dadosIN) into clean, single-event data words for the processor's IN instruction.
- Synchronizes and debounces the key, captures the switches once per press into a one-entry buffer, and answers the control unit's wait request with a one-cycle pronto pulse plus a 32-bit extended word.
- Sits between the board pins and the Rmem input mux, replacing the bare pulse generator on the key.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a press or a release (range 1..255).
- SIGN_EXT, 0: 1 = sign-extend the captured byte to 32 bits; 0 = zero-extend.

Ports:
- clk  in  1  system clock (divided clock); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- chave  in  1  raw enter key, asynchronous, active-high when pressed.
- dadosIN  in  8  raw switch bank, asynchronous.
- req  in  1  from control unit; held high while an IN instruction waits for data.
- dados  out  32  last delivered word; stable between deliveries.
- pronto  out  1  one-cycle pulse; dados is valid in the same cycle.
- aguardando  out  1  req high and buffer empty (LED "waiting for user").
- perdido  out  1  sticky overrun flag; an unread capture was overwritten.

Behaviour:
- Reset (sync, rst=1 at a rising edge) forces:
  - dados=0, pronto=0, perdido=0.
  - Buffer empty (buf_valid=0), FSM=OCIOSO, debounce counter=0, synchronizer flops=0.
  - rst has priority over every other event, including a press or delivery in progress.
- Synchronizer: chave passes through 2 flops, giving k_s. dadosIN passes through 2 flops, giving d_s. Only k_s and d_s are used internally.
- FSM states: OCIOSO, CONFIRMA, PRESSIONADO, SOLTA.
  - OCIOSO: k_s=1 -> CONFIRMA, cnt=1.
  - CONFIRMA:
    - k_s=0 -> OCIOSO, cnt=0 (glitch rejected, no capture).
    - k_s=1 and cnt<DEBOUNCE_CYCLES -> cnt+1.
    - k_s=1 and cnt==DEBOUNCE_CYCLES -> capture d_s into buffer, buf_valid=1, go to PRESSIONADO, cnt=0.
  - PRESSIONADO: k_s=0 -> SOLTA, cnt=1.
  - SOLTA:
    - k_s=1 -> PRESSIONADO (bounce on release, no new capture).
    - k_s=0 for DEBOUNCE_CYCLES consecutive cycles -> OCIOSO.
  - Exactly one capture per physical press, however long the key is held.
- Latency:
  - Raw chave rise to capture: 2 + DEBOUNCE_CYCLES + 1 edges, given a clean input.
  - Capture to pronto: 1 cycle when req is high.
- Delivery, evaluated at each edge when req=1 and buf_valid=1:
  - Next cycle: pronto=1 and dados=extend(buffer); buf_valid cleared.
  - Otherwise pronto=0.
  - pronto never asserts on two consecutive cycles unless a new capture lands in between.
- Extension:
  - SIGN_EXT=0: dados = {24'd0, byte}.
  - SIGN_EXT=1: dados = {{24{byte[7]}}, byte}.
- Simultaneous capture and delivery at the same edge: the old buffer value is delivered, the new byte is loaded, and buf_valid stays 1. perdido is not set.
- Capture while buf_valid=1 and no delivery at that edge: the buffer is overwritten with the new byte and perdido is set to 1 (sticky until rst).
- req drops before delivery: no effect; the buffer is kept for the next request.
- req high with an empty buffer: aguardando=1 (combinational: req & ~buf_valid); no pronto.
- The control unit must drop req in the cycle after it sees pronto. If req stays high, the next capture produces another pronto.

Test Plan:
- Reset check: rst high 2 cycles with chave=1 and dadosIN=8'hFF -> after release dados=0, pronto=0, perdido=0, aguardando=req; no capture until chave is seen low then high again.
- Clean press, DEBOUNCE_CYCLES=4, SIGN_EXT=0: dadosIN=8'hA5, req=1, chave high 20 cycles -> exactly one pronto, 8 edges after the chave rise, dados=32'h000000A5; aguardando 1 before, 0 after pronto.
- Bounce rejection: chave high 2 cycles, low 1, high 2, low -> no capture, no pronto, FSM back in OCIOSO. Release bounce during a long press -> still only one capture.
- Buffered press and sign extension, SIGN_EXT=1: press with dadosIN=8'h80 while req=0 -> no pronto. Later raise req -> pronto next cycle with dados=32'hFFFFFF80.
- Overrun: two presses (8'h01 then 8'h02) with req=0 -> perdido=1. Raise req -> dados=32'h00000002. perdido stays 1 until rst.
- Simultaneous capture and delivery: align a capture of 8'h11 with the delivery edge of buffered 8'h22 -> pronto with dados=32'h22, buf_valid stays 1, and the next req cycle delivers 32'h11; perdido=0.
